// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared encodings and PN generator helpers for the JESD204 TPL DAC core.
package ad_ip_jesd204_tpl_dac_pkg;

    typedef enum logic [3:0] {
        SEL_DMA  = 4'd0,
        SEL_PAT  = 4'd1,
        SEL_PN7  = 4'd2,
        SEL_PN15 = 4'd3
    } dac_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ARMED = 1'b1
    } sync_state_e;

    localparam int PN_MAX_W = 15;
    localparam int PN7_W    = 7;
    localparam int PN15_W   = 15;
    localparam logic [PN_MAX_W-1:0] PN7_SEED  = {PN_MAX_W{1'b1}} >> (PN_MAX_W - PN7_W);
    localparam logic [PN_MAX_W-1:0] PN15_SEED = {PN_MAX_W{1'b1}} >> (PN_MAX_W - PN15_W);

    // One Fibonacci step of x^w + x^(w-1) + 1; the new bit lands in bit 0.
    function automatic logic [PN_MAX_W-1:0] pn_shift(input logic [PN_MAX_W-1:0] s, input int w);
        logic                nb;
        logic [PN_MAX_W-1:0] mask;
        mask = {PN_MAX_W{1'b1}} >> (PN_MAX_W - w);
        nb   = s[w-1] ^ s[w-2];
        return ((s << 1) | {{(PN_MAX_W-1){1'b0}}, nb}) & mask;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_framer.sv
// Registered sample-to-lane-octet mapping; a lane word shorter than the beat is repeated to fill it.
module ad_ip_jesd204_tpl_dac_framer #(
    parameter int NUM_LANES         = 1,
    parameter int NUM_CHANNELS      = 1,
    parameter int SAMPLES_PER_FRAME = 1,
    parameter int BITS_PER_SAMPLE   = 16,
    parameter int OCTETS_PER_BEAT   = 4,
    parameter int DATA_PATH_WIDTH   = 1
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic                                        en,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] din,
    output logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0]      dout
);

    localparam int F  = NUM_CHANNELS*SAMPLES_PER_FRAME*BITS_PER_SAMPLE/(8*NUM_LANES);
    localparam int LO = DATA_PATH_WIDTH*NUM_CHANNELS*BITS_PER_SAMPLE/(8*NUM_LANES);
    localparam int SB = SAMPLES_PER_FRAME*BITS_PER_SAMPLE;

    logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0] mapped;

    // P is the bit position inside a frame counted from its first-transmitted (MSB) bit.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        for (genvar j = 0; j < OCTETS_PER_BEAT; j++) begin : g_oct
            for (genvar b = 0; b < 8; b++) begin : g_bit
                localparam int JJ  = j % LO;
                localparam int FI  = JJ / F;
                localparam int K   = l*F + (JJ % F);
                localparam int P   = K*8 + (7 - b);
                localparam int C   = P / SB;
                localparam int SI  = (P % SB) / BITS_PER_SAMPLE;
                localparam int BB  = P % BITS_PER_SAMPLE;
                localparam int IDX = C*DATA_PATH_WIDTH*BITS_PER_SAMPLE
                                   + (FI*SAMPLES_PER_FRAME + SI)*BITS_PER_SAMPLE
                                   + (BITS_PER_SAMPLE - 1 - BB);
                assign mapped[l*OCTETS_PER_BEAT*8 + j*8 + b] = din[IDX];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)  dout <= '0;
        else if (en)  dout <= mapped;
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_core.sv
// JESD204 TPL DAC core: source mux, sync arming, framer.
// Define TPL_DAC_PN_GEN_EN to include the PN7/PN15 generators.
module ad_ip_jesd204_tpl_dac_core
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int NUM_LANES            = 1,
    parameter int NUM_CHANNELS         = 1,
    parameter int SAMPLES_PER_FRAME    = 1,
    parameter int CONVERTER_RESOLUTION = 14,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int OCTETS_PER_BEAT      = 4,
    parameter int DATA_PATH_WIDTH      = 1,
    parameter int LINK_DATA_WIDTH      = NUM_LANES*OCTETS_PER_BEAT*8,
    parameter int DMA_DATA_WIDTH       = DATA_PATH_WIDTH*BITS_PER_SAMPLE*NUM_CHANNELS
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [NUM_CHANNELS*4-1:0]               dac_data_sel,
    input  logic [NUM_CHANNELS*BITS_PER_SAMPLE-1:0] dac_pat_data,
    output logic [NUM_CHANNELS-1:0]                 dac_valid,
    input  logic [DMA_DATA_WIDTH-1:0]               dac_ddata,
    input  logic                                    dac_sync,
    input  logic                                    dac_external_sync,
    output logic                                    dac_sync_status,
    output logic                                    link_valid,
    input  logic                                    link_ready,
    output logic [LINK_DATA_WIDTH-1:0]              link_data
);

    localparam int CH_W = DATA_PATH_WIDTH*BITS_PER_SAMPLE;
    localparam logic [BITS_PER_SAMPLE-1:0] SMP_MASK =
        {BITS_PER_SAMPLE{1'b1}} << (BITS_PER_SAMPLE - CONVERTER_RESOLUTION);

    logic        pipe_en, armed, ext_q, ext_edge;
    sync_state_e state, state_nxt;
    logic [CH_W-1:0]              pn7_word, pn15_word;
    logic [NUM_CHANNELS*CH_W-1:0] s1_flat;

    assign pipe_en = link_ready | ~link_valid;

    always_ff @(posedge clk) begin
        if (!resetn) link_valid <= 1'b0;
        else         link_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ext_q    <= 1'b0;
            ext_edge <= 1'b0;
        end else begin
            ext_q    <= dac_external_sync;
            ext_edge <= dac_external_sync & ~ext_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    // A pending arm request outranks a release edge in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (dac_sync) state_nxt = ST_ARMED;
            ST_ARMED: if (ext_edge && !dac_sync) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        armed           = (state == ST_ARMED);
        dac_sync_status = armed;
    end

`ifdef TPL_DAC_PN_GEN_EN
    localparam int PNB = DATA_PATH_WIDTH*CONVERTER_RESOLUTION;

    logic [PN_MAX_W-1:0] pn7_q, pn15_q, pn7_nxt, pn15_nxt;
    logic [PNB-1:0]      pn7_bits, pn15_bits;

    // Earliest generated bit ends up at the MSB of the bit vector.
    always_comb begin
        pn7_nxt   = pn7_q;
        pn15_nxt  = pn15_q;
        pn7_bits  = '0;
        pn15_bits = '0;
        for (int i = 0; i < PNB; i++) begin
            pn7_nxt            = pn_shift(pn7_nxt, PN7_W);
            pn15_nxt           = pn_shift(pn15_nxt, PN15_W);
            pn7_bits[PNB-1-i]  = pn7_nxt[0];
            pn15_bits[PNB-1-i] = pn15_nxt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || armed) begin
            pn7_q  <= PN7_SEED;
            pn15_q <= PN15_SEED;
        end else if (pipe_en) begin
            pn7_q  <= pn7_nxt;
            pn15_q <= pn15_nxt;
        end
    end

    for (genvar d = 0; d < DATA_PATH_WIDTH; d++) begin : g_pn_smp
        assign pn7_word[d*BITS_PER_SAMPLE +: BITS_PER_SAMPLE] =
            BITS_PER_SAMPLE'(pn7_bits[PNB-1-d*CONVERTER_RESOLUTION -: CONVERTER_RESOLUTION])
                << (BITS_PER_SAMPLE - CONVERTER_RESOLUTION);
        assign pn15_word[d*BITS_PER_SAMPLE +: BITS_PER_SAMPLE] =
            BITS_PER_SAMPLE'(pn15_bits[PNB-1-d*CONVERTER_RESOLUTION -: CONVERTER_RESOLUTION])
                << (BITS_PER_SAMPLE - CONVERTER_RESOLUTION);
    end
`else
    assign pn7_word  = '0;
    assign pn15_word = '0;
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [3:0]      sel;
        logic [CH_W-1:0] src, s1;

        assign sel = dac_data_sel[c*4 +: 4];

        always_comb begin
            case (sel)
                SEL_DMA:  src = dac_ddata[c*CH_W +: CH_W];
                SEL_PAT:  src = {DATA_PATH_WIDTH{dac_pat_data[c*BITS_PER_SAMPLE +: BITS_PER_SAMPLE]}};
                SEL_PN7:  src = pn7_word;
                SEL_PN15: src = pn15_word;
                default:  src = '0;
            endcase
        end

        assign dac_valid[c] = pipe_en & ~armed & resetn & (sel == SEL_DMA);

        always_ff @(posedge clk) begin
            if (!resetn)      s1 <= '0;
            else if (pipe_en) s1 <= armed ? '0 : (src & {DATA_PATH_WIDTH{SMP_MASK}});
        end

        assign s1_flat[c*CH_W +: CH_W] = s1;
    end

    ad_ip_jesd204_tpl_dac_framer #(
        .NUM_LANES         (NUM_LANES),
        .NUM_CHANNELS      (NUM_CHANNELS),
        .SAMPLES_PER_FRAME (SAMPLES_PER_FRAME),
        .BITS_PER_SAMPLE   (BITS_PER_SAMPLE),
        .OCTETS_PER_BEAT   (OCTETS_PER_BEAT),
        .DATA_PATH_WIDTH   (DATA_PATH_WIDTH)
    ) i_framer (
        .clk    (clk),
        .resetn (resetn),
        .en     (pipe_en),
        .din    (s1_flat),
        .dout   (link_data)
    );

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_core.sv
// Randomized bench for ad_ip_jesd204_tpl_dac_core (default parameters, one lane, one channel).
module tb_ad_ip_jesd204_tpl_dac_core;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  dac_data_sel;
    logic [15:0] dac_pat_data;
    logic [0:0]  dac_valid;
    logic [15:0] dac_ddata;
    logic        dac_sync, dac_external_sync, dac_sync_status;
    logic        link_valid, link_ready;
    logic [31:0] link_data;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_dac_core dut (
        .clk               (clk),
        .resetn            (resetn),
        .dac_data_sel      (dac_data_sel),
        .dac_pat_data      (dac_pat_data),
        .dac_valid         (dac_valid),
        .dac_ddata         (dac_ddata),
        .dac_sync          (dac_sync),
        .dac_external_sync (dac_external_sync),
        .dac_sync_status   (dac_sync_status),
        .link_valid        (link_valid),
        .link_ready        (link_ready),
        .link_data         (link_data)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus held for one cycle
    logic        st_resetn, st_ready, st_sync, st_ext;
    logic [3:0]  st_sel;
    logic [15:0] st_pat, st_dma;

    // reference model state
    bit          m_valid, m_armed, m_ext_prev, m_edge, consumed, exp_dv;
    logic [31:0] m_link;
    logic [15:0] m_s1;
    int          m_pn7_idx, m_pn15_idx;
    bit          pn7_seq[127];
    bit          pn15_seq[32767];

    function automatic logic [15:0] pn_sample(input bit long, input int idx);
        logic [15:0] v = '0;
        for (int b = 0; b < 14; b++)
            v[15-b] = long ? pn15_seq[(idx+b) % 32767] : pn7_seq[(idx+b) % 127];
        return v;
    endfunction

    function automatic logic [15:0] src_sample();
        case (st_sel)
            4'd0: return st_dma & 16'hFFFC;
            4'd1: return st_pat & 16'hFFFC;
`ifdef TPL_DAC_PN_GEN_EN
            4'd2: return pn_sample(1'b0, m_pn7_idx);
            4'd3: return pn_sample(1'b1, m_pn15_idx);
`endif
            default: return 16'h0;
        endcase
    endfunction

    // Sample MSB octet goes out first and sits in lane bits [7:0]; the 2-octet frame repeats.
    function automatic logic [31:0] frame(input logic [15:0] s);
        return {s[7:0], s[15:8], s[7:0], s[15:8]};
    endfunction

    task automatic cycle();
        bit pe, nxt_armed;
        @(negedge clk);
        check("link_valid", link_valid, m_valid);
        check("link_data", link_data, m_link);
        check("sync_status", dac_sync_status, m_armed);
        resetn = st_resetn; link_ready = st_ready; dac_sync = st_sync;
        dac_external_sync = st_ext; dac_data_sel = st_sel; dac_pat_data = st_pat; dac_ddata = st_dma;
        #1;
        exp_dv = st_resetn && (st_ready || !m_valid) && !m_armed && (st_sel == 4'd0);
        check("dac_valid", dac_valid, exp_dv);
        @(posedge clk);
        consumed = 0;
        if (!st_resetn) begin
            m_valid = 0; m_link = '0; m_s1 = '0; m_armed = 0;
            m_ext_prev = 0; m_edge = 0; m_pn7_idx = 0; m_pn15_idx = 0;
        end else begin
            pe = st_ready || !m_valid;
            consumed = exp_dv;
            if (pe) begin
                m_link = frame(m_s1);
                m_s1   = m_armed ? 16'h0 : src_sample();
            end
            if (m_armed) begin
                m_pn7_idx = 0; m_pn15_idx = 0;
            end else if (pe) begin
                m_pn7_idx  = (m_pn7_idx + 14) % 127;
                m_pn15_idx = (m_pn15_idx + 14) % 32767;
            end
            nxt_armed  = st_sync ? 1'b1 : ((m_armed && m_edge) ? 1'b0 : m_armed);
            m_edge     = st_ext && !m_ext_prev;
            m_ext_prev = st_ext;
            m_armed    = nxt_armed;
            m_valid    = 1;
        end
    endtask

    initial begin
        logic [6:0]  s7;
        logic [14:0] s15;
        logic [15:0] r;
        s7 = '1;
        for (int i = 0; i < 127; i++) begin
            s7 = {s7[5:0], s7[6] ^ s7[5]};
            pn7_seq[i] = s7[0];
        end
        s15 = '1;
        for (int i = 0; i < 32767; i++) begin
            s15 = {s15[13:0], s15[14] ^ s15[13]};
            pn15_seq[i] = s15[0];
        end

        st_resetn = 0; st_ready = 1; st_sync = 0; st_ext = 0;
        st_sel = 4'd1; st_pat = 16'hA5A0; st_dma = '0;
        resetn = 0; link_ready = 1; dac_sync = 0; dac_external_sync = 0;
        dac_data_sel = 4'd1; dac_pat_data = 16'hA5A0; dac_ddata = '0;
        repeat (3) cycle();

        // constant pattern
        st_resetn = 1;
        repeat (4) cycle();
        #1 check("pattern_word", link_data, 32'hA0A5A0A5);

        // DMA ramp with a 3-cycle backpressure window
        st_sel = 4'd0; r = 16'h0004;
        for (int i = 0; i < 30; i++) begin
            st_dma   = r;
            st_ready = !(i >= 10 && i < 13);
            cycle();
            if (consumed) r = r + 16'h0004;
        end
        st_ready = 1;

        // arm, then release with an external edge; then arm request overlapping an edge
        st_sel = 4'd1; st_pat = 16'h1234;
        st_sync = 1; cycle(); st_sync = 0;
        repeat (3) cycle();
        st_ext = 1; cycle(); st_ext = 0;
        repeat (6) cycle();
        st_sync = 1; repeat (2) cycle();
        st_ext = 1; repeat (2) cycle();
        st_ext = 0; st_sync = 0;
        repeat (5) cycle();

        // PN7 from reset
        st_resetn = 0; st_sel = 4'd2; repeat (2) cycle();
        st_resetn = 1; repeat (2) cycle();
`ifdef TPL_DAC_PN_GEN_EN
        #1 check("pn7_first_bits", link_data[7:1], 7'b0000001);
`else
        #1 check("pn_disabled_zero", link_data, 32'h0);
`endif
        for (int i = 0; i < 40; i++) begin
            st_ready = ($urandom % 4) != 0;
            cycle();
        end

        // fully random traffic including mid-run resets
        for (int i = 0; i < 600; i++) begin
            st_resetn = ($urandom % 100) != 0;
            st_ready  = ($urandom % 4) != 0;
            st_sel    = 4'($urandom_range(0, 5));
            st_pat    = 16'($urandom);
            st_dma    = 16'($urandom);
            st_sync   = ($urandom % 20) == 0;
            st_ext    = ($urandom % 3) == 0;
            cycle();
        end

        // PN15 over more than one full period
        st_resetn = 0; st_sync = 0; st_ext = 0; st_ready = 1; st_sel = 4'd3;
        repeat (2) cycle();
        st_resetn = 1;
        repeat (2400) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
